// File: rtl/user_mgr_obi_arb_pkg.sv
// Shared types for the user-domain OBI manager arbiter: requester naming,
// index types, OBI request/response structs and the arbiter state encoding.
package user_mgr_obi_arb_pkg;

  localparam int unsigned NumUserMgr = 2;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_width(NumUserMgr)-1:0] user_mgr_idx_t;

  typedef enum user_mgr_idx_t {
    UserMgrScrubber = 0,
    UserMgrLoader   = 1
  } user_mgr_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_r_t;

  typedef struct packed {
    logic   gnt;
    logic   rvalid;
    obi_r_t r;
  } obi_rsp_t;

  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

endpackage

// File: rtl/user_mgr_idx_fifo.sv
// Small synchronous FIFO of requester indices; a pop and a push in the same
// cycle are allowed even when full, since the read is taken before the write.
module user_mgr_idx_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    if (pop_i)  rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    count_d = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/user_mgr_obi_arb.sv
// Round-robin arbiter sharing one OBI manager port between user requesters;
// locks an ungranted request and routes each response back to its issuer.
module user_mgr_obi_arb
  import user_mgr_obi_arb_pkg::*;
#(
  parameter int unsigned NumMgr      = 2,
  parameter int unsigned NumMaxTrans = 2,
  parameter type         mgr_obi_req_t = obi_req_t,
  parameter type         mgr_obi_rsp_t = obi_rsp_t
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      testmode_i,
  input  mgr_obi_req_t [NumMgr-1:0] req_i,
  output mgr_obi_rsp_t [NumMgr-1:0] rsp_o,
  output mgr_obi_req_t              mgr_req_o,
  input  mgr_obi_rsp_t              mgr_rsp_i,
  output logic                      busy_o,
  output logic                      rsp_err_o,
  output arb_state_e                dbg_state_o
);
  localparam int unsigned IdxW = idx_width(NumMgr);
  localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

  // Handshake: a request is transferred when mgr_req_o.req & mgr_rsp_i.gnt;
  // an ungranted request stays forwarded unchanged until that happens.
  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d, lock_q, lock_d, winner, sel, head;
  logic            found, fwd, accept, pop, full, empty, block;
  logic [CntW-1:0] count;
  logic            unused_testmode;

  assign unused_testmode = testmode_i;

  // A response in this cycle frees a slot before the new push lands.
  assign block = full & ~mgr_rsp_i.rvalid;

  always_comb begin : p_pick
    int unsigned k;
    logic [IdxW-1:0] kk;
    winner = '0;
    found  = 1'b0;
    k      = 0;
    kk     = '0;
    for (int i = 0; i < NumMgr; i++) begin
      k  = (int'(rr_q) + i) % NumMgr;
      kk = IdxW'(k);
      if (!found && !block && req_i[kk].req) begin
        found  = 1'b1;
        winner = kk;
      end
    end
  end

  assign sel       = (state_q == ArbLocked) ? lock_q : winner;
  assign fwd       = (state_q == ArbLocked) | found;
  assign mgr_req_o = fwd ? req_i[sel] : '0;
  assign accept    = mgr_req_o.req & mgr_rsp_i.gnt;
  assign pop       = mgr_rsp_i.rvalid & ~empty;
  assign rsp_err_o = mgr_rsp_i.rvalid & empty;

  always_comb begin
    rsp_o = '0;
    rsp_o[sel].gnt = accept;
    if (pop) begin
      rsp_o[head].rvalid = 1'b1;
      rsp_o[head].r      = mgr_rsp_i.r;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    case (state_q)
      ArbIdle: begin
        if (found && !accept) begin
          state_d = ArbLocked;
          lock_d  = winner;
        end
      end
      ArbLocked: begin
        // A requester that drops its request releases the lock ungranted.
        if (accept || !req_i[lock_q].req) state_d = ArbIdle;
      end
      default: state_d = ArbIdle;
    endcase
    if (accept) rr_d = (sel == IdxW'(NumMgr - 1)) ? '0 : sel + IdxW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ArbIdle;
      rr_q    <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
    end
  end

  user_mgr_idx_fifo #(
    .Depth (NumMaxTrans),
    .Width (IdxW)
  ) i_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign busy_o      = (count != '0) | (state_q == ArbLocked);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_user_mgr_obi_arb.sv
// Bench for user_mgr_obi_arb: directed scenarios followed by random traffic,
// all checked against an issuer-queue reference model.
module tb_user_mgr_obi_arb;
  import user_mgr_obi_arb_pkg::*;

  localparam int N  = 3;
  localparam int MT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic testmode = 1'b0;
  obi_req_t [N-1:0] req;
  obi_rsp_t [N-1:0] rsp;
  obi_req_t         mreq;
  obi_rsp_t         mrsp;
  logic             busy, err;
  arb_state_e       dbg;

  always #5 clk = ~clk;

  user_mgr_obi_arb #(
    .NumMgr      (N),
    .NumMaxTrans (MT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .testmode_i  (testmode),
    .req_i       (req),
    .rsp_o       (rsp),
    .mgr_req_o   (mreq),
    .mgr_rsp_i   (mrsp),
    .busy_o      (busy),
    .rsp_err_o   (err),
    .dbg_state_o (dbg)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: issuers of outstanding transactions in order, the next
  // round-robin start, and the requester owning the port while ungranted.
  int exp_q[$];
  int rr = 0;
  int owner = -1;
  int last_acc = -1;

  obi_req_t         exp_req;
  obi_rsp_t [N-1:0] exp_rsp;
  logic             exp_err, exp_busy;
  int               m_sel;
  logic             m_fwd, m_acc;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_eval();
    bit blk;
    blk   = (exp_q.size() == MT) && !mrsp.rvalid;
    m_sel = -1;
    m_fwd = 1'b0;
    if (owner >= 0) begin
      m_sel = owner;
      m_fwd = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        int k = (rr + i) % N;
        if (m_sel < 0 && !blk && req[k].req) begin
          m_sel = k;
          m_fwd = 1'b1;
        end
      end
    end
    exp_req = '0;
    m_acc   = 1'b0;
    if (m_fwd) begin
      exp_req = req[m_sel];
      m_acc   = req[m_sel].req && mrsp.gnt;
    end
    exp_rsp = '0;
    if (m_acc) exp_rsp[m_sel].gnt = 1'b1;
    exp_err = 1'b0;
    if (mrsp.rvalid) begin
      if (exp_q.size() > 0) begin
        exp_rsp[exp_q[0]].rvalid = 1'b1;
        exp_rsp[exp_q[0]].r      = mrsp.r;
      end else begin
        exp_err = 1'b1;
      end
    end
    exp_busy = (exp_q.size() != 0) || (owner >= 0);
  endtask

  task automatic eval_check();
    #1;
    model_eval();
    check("mgr_req", mreq, exp_req);
    check("rsp", rsp, exp_rsp);
    check("busy", busy, exp_busy);
    check("rsp_err", err, exp_err);
    check("state", dbg == ArbLocked, owner >= 0);
  endtask

  task automatic advance();
    @(posedge clk);
    if (mrsp.rvalid && exp_q.size() > 0) void'(exp_q.pop_front());
    last_acc = -1;
    if (m_acc) begin
      exp_q.push_back(m_sel);
      rr       = (m_sel + 1) % N;
      owner    = -1;
      last_acc = m_sel;
    end else if (owner >= 0) begin
      if (!req[owner].req) owner = -1;
    end else if (m_fwd) begin
      owner = m_sel;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] reqv, input logic gnt, input logic rv,
                       input logic [31:0] rdata);
    for (int k = 0; k < N; k++) begin
      req[k].req   = reqv[k];
      req[k].we    = 1'b0;
      req[k].be    = 4'hF;
      req[k].addr  = 32'h1000 * (k + 1);
      req[k].wdata = 32'h0;
    end
    mrsp.gnt     = gnt;
    mrsp.rvalid  = rv;
    mrsp.r.rdata = rdata;
    mrsp.r.err   = 1'b0;
  endtask

  initial begin
    int ord[4];
    ord = '{0, 1, 0, 1};
    req  = '0;
    mrsp = '0;

    // Reset values
    #1;
    check("rst_mgr_req", mreq, 70'h0);
    check("rst_rsp", rsp, 105'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Stray response with nothing outstanding
    drive(3'b000, 1'b0, 1'b1, 32'hDEADBEEF);
    eval_check();
    check("stray_err", err, 1'b1);
    check("stray_rvalid", {rsp[2].rvalid, rsp[1].rvalid, rsp[0].rvalid}, 3'b000);
    advance();
    drive(3'b000, 1'b0, 1'b0, 32'h0);
    eval_check();
    check("stray_err_clear", err, 1'b0);
    advance();

    // Two continuous requesters alternate; responses return in order
    for (int i = 0; i < 4; i++) begin
      drive(3'b011, 1'b1, i > 0, 32'hA0 + i);
      eval_check();
      check("alt_addr", mreq.addr, 32'h1000 * (ord[i] + 1));
      check("alt_gnt", rsp[ord[i]].gnt, 1'b1);
      if (i > 0) check("alt_ret", rsp[ord[i-1]].rvalid, 1'b1);
      advance();
    end
    drive(3'b000, 1'b0, 1'b1, 32'hA4);
    eval_check();
    check("alt_ret_last", rsp[1].rvalid, 1'b1);
    advance();

    // Requester 1 held ungranted while requester 0 joins
    for (int i = 0; i < 3; i++) begin
      drive((i >= 1) ? 3'b011 : 3'b010, 1'b0, 1'b0, 32'h0);
      eval_check();
      check("lock_addr", mreq.addr, 32'h2000);
      check("lock_no_gnt0", rsp[0].gnt, 1'b0);
      advance();
    end
    drive(3'b011, 1'b1, 1'b0, 32'h0);
    eval_check();
    check("lock_release_addr", mreq.addr, 32'h2000);
    check("lock_release_gnt1", rsp[1].gnt, 1'b1);
    advance();
    drive(3'b001, 1'b1, 1'b0, 32'h0);
    eval_check();
    check("after_lock_gnt0", rsp[0].gnt, 1'b1);
    advance();

    // Outstanding limit reached: no forwarding until a response frees a slot
    drive(3'b100, 1'b1, 1'b0, 32'h0);
    eval_check();
    check("full_blocked", mreq.req, 1'b0);
    check("full_busy", busy, 1'b1);
    advance();
    drive(3'b100, 1'b1, 1'b1, 32'h77);
    eval_check();
    check("full_ret_oldest", rsp[1].rvalid, 1'b1);
    check("full_swap_gnt2", rsp[2].gnt, 1'b1);
    advance();
    drive(3'b100, 1'b1, 1'b0, 32'h0);
    eval_check();
    check("still_full", mreq.req, 1'b0);
    advance();
    drive(3'b000, 1'b0, 1'b1, 32'h78);
    eval_check();
    check("drain_ret0", rsp[0].rvalid, 1'b1);
    advance();
    drive(3'b000, 1'b0, 1'b1, 32'h79);
    eval_check();
    check("drain_ret2", rsp[2].rvalid, 1'b1);
    advance();

    // Single requester 2 back-to-back
    drive(3'b100, 1'b1, 1'b0, 32'h0);
    eval_check();
    check("b2b_gnt_a", rsp[2].gnt, 1'b1);
    advance();
    drive(3'b100, 1'b1, 1'b1, 32'h0000_00A5);
    eval_check();
    check("b2b_gnt_b", rsp[2].gnt, 1'b1);
    check("b2b_data_a", rsp[2].r.rdata, 32'h0000_00A5);
    advance();
    drive(3'b000, 1'b0, 1'b1, 32'h0000_005A);
    eval_check();
    check("b2b_data_b", {rsp[2].rvalid, rsp[2].r.rdata}, {1'b1, 32'h0000_005A});
    advance();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (req[k].req && last_acc != k && $urandom_range(0, 15) != 0) begin
          // hold the pending request stable
        end else begin
          req[k].req = 1'($urandom_range(0, 1));
          if (req[k].req) begin
            req[k].we    = 1'($urandom_range(0, 1));
            req[k].be    = 4'($urandom_range(0, 15));
            req[k].addr  = $urandom();
            req[k].wdata = $urandom();
          end
        end
      end
      mrsp.gnt     = ($urandom_range(0, 3) != 0);
      mrsp.rvalid  = ($urandom_range(0, 2) == 0);
      mrsp.r.rdata = $urandom();
      mrsp.r.err   = 1'($urandom_range(0, 1));
      eval_check();
      advance();
    end

    // Drain everything before the reset scenario
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && owner < 0) break;
      drive(3'b000, 1'b0, exp_q.size() > 0, 32'h0);
      eval_check();
      advance();
    end
    check("drained", busy, 1'b0);

    // Reset while two transactions are outstanding
    drive(3'b001, 1'b1, 1'b0, 32'h0);
    eval_check();
    advance();
    drive(3'b001, 1'b1, 1'b0, 32'h0);
    eval_check();
    advance();
    drive(3'b001, 1'b1, 1'b0, 32'h0);
    #1;
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_blocked", mreq.req, 1'b0);
    req   = '0;
    mrsp  = '0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_mgr_req", mreq, 70'h0);
    check("mid_rst_rsp", rsp, 105'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err, 1'b0);
    exp_q.delete();
    rr    = 0;
    owner = -1;
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b000, 1'b0, 1'b1, 32'h1234_5678);
    eval_check();
    check("post_rst_err", err, 1'b1);
    advance();
    drive(3'b000, 1'b0, 1'b0, 32'h0);
    eval_check();
    advance();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/user_mgr_obi_arb.md
Name: user_mgr_obi_arb

Overview:
- Round-robin arbiter that shares the single user-domain OBI manager port (user_mgr_obi_req_o / user_mgr_obi_rsp_i) between several in-domain requesters, e.g. a scrubber and a test-pattern loader for the radiation-hardened design.
- Holds each granted request stable until the crossbar grants it.
- Tracks outstanding transactions so every response returns to the requester that issued it.
- Sits in user_domain between the user requesters and the Croc subordinate crossbar.

Parameters:
- NumMgr, 2, number of requesters; legal range 2..8.
- NumMaxTrans, 2, maximum outstanding transactions on the shared port; legal range 1..4.
- mgr_obi_req_t, croc_pkg::mgr_obi_req_t, OBI request struct type.
- mgr_obi_rsp_t, croc_pkg::mgr_obi_rsp_t, OBI response struct type.

Ports:
- clk_i  input  1  system clock; the only clock.
- rst_ni  input  1  asynchronous active-low reset.
- testmode_i  input  1  test mode; unused except for lint tie-off.
- req_i  input  NumMgr x mgr_obi_req_t  requester-side OBI requests.
- rsp_o  output  NumMgr x mgr_obi_rsp_t  requester-side OBI responses.
- mgr_req_o  output  mgr_obi_req_t  shared OBI request towards the crossbar.
- mgr_rsp_i  input  mgr_obi_rsp_t  shared OBI response from the crossbar.
- busy_o  output  1  high while any transaction is outstanding or a request is locked.
- rsp_err_o  output  1  one-cycle pulse when rvalid arrives with no outstanding transaction.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous, active-low on rst_ni. All state clears on reset.
- Reset values:
  - mgr_req_o = '0; all rsp_o = '0.
  - busy_o = 0; rsp_err_o = 0.
  - RR pointer = 0; lock cleared; outstanding count = 0; index FIFO empty.
- Arbitration state machine, states IDLE and LOCKED:
  - IDLE: eligible requesters are those with req_i[k].req = 1, masked to none while outstanding count == NumMaxTrans. Pick the first eligible index at or above the RR pointer, wrapping modulo NumMgr. Drive mgr_req_o = req_i[winner] combinationally, so there is zero added latency on the request path.
  - IDLE, gnt = 1 in the same cycle: accept the transaction, stay in IDLE, set RR pointer = (winner + 1) mod NumMgr.
  - IDLE, gnt = 0: register the winner and move to LOCKED.
  - LOCKED: keep forwarding the locked requester regardless of other requests, per the OBI rule that a request stays asserted until granted. On gnt, return to IDLE and set RR pointer = locked + 1 mod NumMgr.
- Grant routing: rsp_o[sel].gnt = mgr_rsp_i.gnt. gnt to every other requester is 0.
- Transaction accept (req & gnt on the shared port): push the selected index into the index FIFO (depth NumMaxTrans) and increment the outstanding count.
- Response routing:
  - On mgr_rsp_i.rvalid, set rsp_o[fifo_head].rvalid = 1 and rsp_o[fifo_head].r = mgr_rsp_i.r in the same cycle, then pop the FIFO and decrement the count. Response latency through the block is 0.
  - rsp_o[k].r to non-selected requesters is '0.
- Simultaneous accept and rvalid: push and pop in the same cycle, count unchanged. When the FIFO is full, the pop frees the slot before the push lands; no overflow.
- rvalid with empty FIFO: drop it, route to nobody, pulse rsp_err_o for one cycle, count stays 0.
- FIFO full: no new request is forwarded (mgr_req_o.req = 0). A request already in LOCKED cannot occur while full, because it was masked before being locked.
- Dropped request: a requester lowering req while LOCKED violates the protocol. Behaviour is defined as continuing to forward the requester's current (deasserted) req; the lock releases on the next IDLE evaluation without a gnt.
- busy_o = (count != 0) | LOCKED.

Decomposition:
- user_pkg gains:
  - NumUserMgr, the requester count;
  - typedef user_mgr_idx_t, logic [cf_math_pkg::idx_width(NumUserMgr)-1:0];
  - a user_mgr_e enumeration naming each requester index.
- One sub-module: user_mgr_idx_fifo. It is a synchronous FIFO with a count output, same clock and reset, and supports push and pop in the same cycle when full.

Test Plan:
- Reset mid-transaction: assert rst_ni low with 2 outstanding -> all outputs 0, count 0; a later rvalid pulses rsp_err_o.
- Requesters 0 and 1 both request continuously, gnt always 1 -> grants alternate 0,1,0,1; each rvalid returns to its issuer in the same order.
- Requester 1 requests, gnt held 0 for 3 cycles while requester 0 raises req -> mgr_req_o stays requester 1's addr; requester 0 is granted only after gnt is seen for requester 1.
- NumMaxTrans=2 with 2 accepted and no rvalid -> mgr_req_o.req = 0. An rvalid and a new req in the same cycle -> rvalid routed to the oldest index, new request granted, count stays 2.
- rvalid with no outstanding transaction, data 32'hDEADBEEF -> no rsp_o[k].rvalid, rsp_err_o high exactly 1 cycle.
- Single requester 2 of NumMgr=3 issuing back-to-back reads, data 32'h0000_00A5 then 32'h0000_005A -> zero-bubble grants, responses in order on rsp_o[2].
